// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, issues one instruction fetch at a time and buffers the result for decode.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to reject misaligned redirects and pulse MisalignErr.
module fetch_pc_unit #(
   parameter int unsigned           width    = 32,
   parameter logic [width-1:0]      RESET_PC = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PCSrc,
   input  logic [width-1:0] PCTarget,
   output logic             IReqValid,
   input  logic             IReqReady,
   output logic [width-1:0] IReqAddr,
   input  logic             IRespValid,
   input  logic [31:0]      IRespData,
   output logic [31:0]      Instr,
   output logic             InstrValid,
   input  logic             InstrReady,
   output logic [width-1:0] PC,
   output logic [width-1:0] PCPlus4,
   output logic             MisalignErr
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e           state_q, state_d;
   logic [width-1:0] pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             squash_q, squash_d;
   logic             misalign_q, misalign_d;
   logic             redirect;
   logic [width-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect   = PCSrc & ~|PCTarget[1:0];
   assign target     = PCTarget;
   assign misalign_d = PCSrc & |PCTarget[1:0];
`else
   // Low address bits are forced to zero so every redirect lands word-aligned.
   assign redirect   = PCSrc;
   assign target     = PCTarget & {{(width-2){1'b1}}, 2'b00};
   assign misalign_d = 1'b0;
`endif

   assign PC          = pc_q;
   assign PCPlus4     = pc_q + width'(4);
   assign IReqAddr    = pc_q;
   assign Instr       = instr_q;
   assign MisalignErr = misalign_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      squash_d   = squash_q;
      IReqValid  = 1'b0;
      InstrValid = 1'b0;
      case (state_q)
         StIdle: begin
            state_d = StReq;
            if (redirect) pc_d = target;
         end
         StReq: begin
            IReqValid = 1'b1;
            if (redirect) pc_d = target;
            // An accepted request still returns data for the old address; mark it stale.
            if (IReqReady) begin
               state_d  = StWait;
               squash_d = redirect;
            end
         end
         StWait: begin
            if (redirect) begin
               pc_d = target;
               if (IRespValid) begin
                  squash_d = 1'b0;
                  state_d  = StReq;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (IRespValid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = StReq;
               end else begin
                  instr_d = IRespData;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            InstrValid = 1'b1;
            if (redirect) begin
               pc_d    = target;
               state_d = StReq;
            end else if (InstrReady) begin
               pc_d    = PCPlus4;
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         squash_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         squash_q   <= squash_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; inputs change and outputs are sampled 1ns after CLK rises.
module tb_fetch_pc_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        IReqValid;
   logic        IReqReady;
   logic [31:0] IReqAddr;
   logic        IRespValid;
   logic [31:0] IRespData;
   logic [31:0] Instr;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        MisalignErr;

   int checks = 0;
   int errors = 0;

   fetch_pc_unit #(.width(32), .RESET_PC(32'h0)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PCSrc      (PCSrc),
      .PCTarget   (PCTarget),
      .IReqValid  (IReqValid),
      .IReqReady  (IReqReady),
      .IReqAddr   (IReqAddr),
      .IRespValid (IRespValid),
      .IRespData  (IRespData),
      .Instr      (Instr),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .MisalignErr(MisalignErr)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reset, release, then advance one cycle so the unit sits in REQ at PC 0.
   task automatic apply_reset();
      PCSrc = 0; PCTarget = 0; IReqReady = 0; IRespValid = 0; IRespData = 0; InstrReady = 0;
      RST = 0;
      step();
      RST = 1;
      step();
   endtask

   task automatic test_reset();
      PCSrc = 0; PCTarget = 0; IReqReady = 0; IRespValid = 1; IRespData = 32'h1234; InstrReady = 0;
      RST = 0;
      #2;
      checks++;
      if (IReqValid !== 1'b0 || InstrValid !== 1'b0 || MisalignErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: IReqValid=%b InstrValid=%b MisalignErr=%b, want 0 0 0",
                  IReqValid, InstrValid, MisalignErr);
      end
      checks++;
      if (IReqAddr !== 32'h0 || PC !== 32'h0 || PCPlus4 !== 32'h4 || Instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: IReqAddr=%h PC=%h PCPlus4=%h Instr=%h, want 0 0 4 0",
                  IReqAddr, PC, PCPlus4, Instr);
      end
      step();
      RST = 1;
      step();
      // Response outside WAIT must be ignored: unit stays in REQ.
      step();
      IRespValid = 0;
      checks++;
      if (IReqValid !== 1'b1 || IReqAddr !== 32'h0 || InstrValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_to_req: IReqValid=%b IReqAddr=%h InstrValid=%b, want 1 0 0",
                  IReqValid, IReqAddr, InstrValid);
      end
   endtask

   task automatic test_basic_fetch();
      apply_reset();
      IReqReady = 1;
      step();
      IReqReady = 0;
      checks++;
      if (IReqValid !== 1'b0) begin
         errors++;
         $display("FAIL wait_no_req: IReqValid=%b, want 0", IReqValid);
      end
      IRespValid = 1; IRespData = 32'h00500093;
      step();
      IRespValid = 0; IRespData = 32'hFFFF_FFFF;
      checks++;
      if (Instr !== 32'h00500093 || InstrValid !== 1'b1 || PC !== 32'h0) begin
         errors++;
         $display("FAIL basic_fetch: Instr=%h InstrValid=%b PC=%h, want 00500093 1 0",
                  Instr, InstrValid, PC);
      end
   endtask

   // Continues from HOLD at PC 0 left by test_basic_fetch.
   task automatic test_hold_stall();
      InstrReady = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (InstrValid !== 1'b1 || Instr !== 32'h00500093 || IReqValid !== 1'b0 || PC !== 32'h0) begin
            errors++;
            $display("FAIL hold_stall[%0d]: InstrValid=%b Instr=%h IReqValid=%b PC=%h, want 1 00500093 0 0",
                     i, InstrValid, Instr, IReqValid, PC);
         end
      end
      InstrReady = 1;
      step();
      InstrReady = 0;
      checks++;
      if (PC !== 32'h4 || IReqValid !== 1'b1 || InstrValid !== 1'b0 || Instr !== 32'h00500093) begin
         errors++;
         $display("FAIL hold_release: PC=%h IReqValid=%b InstrValid=%b Instr=%h, want 4 1 0 00500093",
                  PC, IReqValid, InstrValid, Instr);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr;
      apply_reset();
      InstrReady = 1;
      for (int i = 0; i < 3; i++) begin
         exp_addr = 32'(i * 4);
         checks++;
         if (IReqValid !== 1'b1 || IReqAddr !== exp_addr) begin
            errors++;
            $display("FAIL b2b_addr[%0d]: IReqValid=%b IReqAddr=%h, want 1 %h",
                     i, IReqValid, IReqAddr, exp_addr);
         end
         IReqReady = 1;
         step();
         IReqReady = 0; IRespValid = 1; IRespData = 32'hA000_0000 + 32'(i);
         step();
         IRespValid = 0;
         checks++;
         if (InstrValid !== 1'b1 || Instr !== 32'hA000_0000 + 32'(i)) begin
            errors++;
            $display("FAIL b2b_instr[%0d]: InstrValid=%b Instr=%h, want 1 %h",
                     i, InstrValid, Instr, 32'hA000_0000 + 32'(i));
         end
         step();
      end
      InstrReady = 0;
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      IReqReady = 1;
      step();
      IReqReady = 0; PCSrc = 1; PCTarget = 32'h100;
      step();
      PCSrc = 0;
      checks++;
      if (PC !== 32'h100 || IReqValid !== 1'b0) begin
         errors++;
         $display("FAIL redir_wait_pc: PC=%h IReqValid=%b, want 100 0", PC, IReqValid);
      end
      IRespValid = 1; IRespData = 32'hDEADBEEF;
      step();
      IRespValid = 0;
      checks++;
      if (InstrValid !== 1'b0 || IReqValid !== 1'b1 || IReqAddr !== 32'h100 || Instr !== 32'h0) begin
         errors++;
         $display("FAIL redir_wait_drop: InstrValid=%b IReqValid=%b IReqAddr=%h Instr=%h, want 0 1 100 0",
                  InstrValid, IReqValid, IReqAddr, Instr);
      end
      // Redirect coinciding with the response in WAIT.
      IReqReady = 1;
      step();
      IReqReady = 0; PCSrc = 1; PCTarget = 32'h200; IRespValid = 1; IRespData = 32'hBAD0BAD0;
      step();
      PCSrc = 0; IRespValid = 0;
      checks++;
      if (InstrValid !== 1'b0 || IReqValid !== 1'b1 || IReqAddr !== 32'h200) begin
         errors++;
         $display("FAIL redir_resp_same: InstrValid=%b IReqValid=%b IReqAddr=%h, want 0 1 200",
                  InstrValid, IReqValid, IReqAddr);
      end
      // Redirect while the request is accepted: the next response is stale.
      PCSrc = 1; PCTarget = 32'h300; IReqReady = 1;
      step();
      PCSrc = 0; IReqReady = 0; IRespValid = 1; IRespData = 32'hCAFE0000;
      step();
      IRespValid = 0;
      checks++;
      if (InstrValid !== 1'b0 || IReqValid !== 1'b1 || IReqAddr !== 32'h300) begin
         errors++;
         $display("FAIL redir_accept_squash: InstrValid=%b IReqValid=%b IReqAddr=%h, want 0 1 300",
                  InstrValid, IReqValid, IReqAddr);
      end
   endtask

   task automatic test_redirect_hold();
      apply_reset();
      IReqReady = 1;
      step();
      IReqReady = 0; IRespValid = 1; IRespData = 32'h11111111;
      step();
      IRespValid = 0; PCSrc = 1; PCTarget = 32'h40; InstrReady = 1;
      step();
      PCSrc = 0; InstrReady = 0;
      checks++;
      if (InstrValid !== 1'b0 || IReqValid !== 1'b1 || IReqAddr !== 32'h40) begin
         errors++;
         $display("FAIL redir_hold: InstrValid=%b IReqValid=%b IReqAddr=%h, want 0 1 40",
                  InstrValid, IReqValid, IReqAddr);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      PCSrc = 1; PCTarget = 32'hFFFFFFFC;
      step();
      PCSrc = 0;
      checks++;
      if (IReqAddr !== 32'hFFFFFFFC || PCPlus4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pcplus4: IReqAddr=%h PCPlus4=%h, want fffffffc 0", IReqAddr, PCPlus4);
      end
      IReqReady = 1;
      step();
      IReqReady = 0; IRespValid = 1; IRespData = 32'h13;
      step();
      IRespValid = 0; InstrReady = 1;
      step();
      InstrReady = 0;
      checks++;
      if (IReqValid !== 1'b1 || IReqAddr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_addr: IReqValid=%b IReqAddr=%h, want 1 0", IReqValid, IReqAddr);
      end
   endtask

   task automatic test_misalign();
      apply_reset();
      PCSrc = 1; PCTarget = 32'h102;
      step();
      PCSrc = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++;
      if (MisalignErr !== 1'b1 || PC !== 32'h0 || IReqValid !== 1'b1) begin
         errors++;
         $display("FAIL misalign_reject: MisalignErr=%b PC=%h IReqValid=%b, want 1 0 1",
                  MisalignErr, PC, IReqValid);
      end
      step();
      checks++;
      if (MisalignErr !== 1'b0 || PC !== 32'h0) begin
         errors++;
         $display("FAIL misalign_pulse: MisalignErr=%b PC=%h, want 0 0", MisalignErr, PC);
      end
`else
      checks++;
      if (MisalignErr !== 1'b0 || IReqAddr !== 32'h100) begin
         errors++;
         $display("FAIL misalign_align: MisalignErr=%b IReqAddr=%h, want 0 100", MisalignErr, IReqAddr);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_hold_stall();
      test_back_to_back();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: width, 32, datapath and address width in bits.
REQ-002 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-003 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous and active-low.
REQ-005 Port: PCSrc  input  1  redirect request, sampled each cycle.
REQ-006 Port: PCTarget  input  width  redirect address, valid when PCSrc=1.
REQ-007 Port: IReqValid  output  1  fetch request to instruction memory.
REQ-008 Port: IReqReady  input  1  instruction memory accepts request.
REQ-009 Port: IReqAddr  output  width  fetch address, equal to PC.
REQ-010 Port: IRespValid  input  1  instruction memory returns data.
REQ-011 Port: IRespData  input  32  returned instruction word.
REQ-012 Port: Instr  output  32  buffered instruction to decode.
REQ-013 Port: InstrValid  output  1  Instr holds a live instruction.
REQ-014 Port: InstrReady  input  1  decode consumes Instr.
REQ-015 Port: PC  output  width  address of the current fetch/buffered instruction.
REQ-016 Port: PCPlus4  output  width  PC+4, combinational.
REQ-017 Port: MisalignErr  output  1  one-cycle pulse on rejected redirect.

Function
REQ-018 PCPlus4 SHALL equal PC+4 modulo 2^width (32'hFFFFFFFC -> 32'h00000000).
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD; state register only.
REQ-020 IDLE: outputs idle; next state REQ unconditionally after one cycle.
REQ-021 REQ: IReqValid=1, IReqAddr=PC; on IReqReady=1 go WAIT, else stay REQ.
REQ-022 At most one request outstanding; IReqValid SHALL be 0 in IDLE, WAIT, HOLD.
REQ-023 WAIT: on IRespValid=1 with squash=0, Instr<=IRespData and go HOLD.
REQ-024 HOLD: InstrValid=1; on InstrReady=1, PC<=PCPlus4, go REQ next cycle.
REQ-025 Redirect (PCSrc=1, accepted) SHALL override next-PC in every state: PC<=PCTarget.
REQ-026 Redirect in IDLE or REQ (no IReqReady): go REQ with new PC; IReqAddr may change.
REQ-027 Redirect in REQ with IReqReady=1 same cycle: old address is accepted, go WAIT with squash=1.
REQ-028 Redirect in WAIT: set squash=1, stay WAIT; PC updated immediately.
REQ-029 WAIT with squash=1 and IRespValid=1: discard data, clear squash, go REQ.
REQ-030 Redirect and IRespValid same cycle in WAIT: response discarded, go REQ.
REQ-031 Redirect in HOLD: InstrValid<=0 next cycle, go REQ; simultaneous InstrReady completes the handshake but PC<=PCTarget, not PCPlus4.
REQ-032 Instr SHALL hold its value outside HOLD; only InstrValid qualifies it.
REQ-033 IRespValid outside WAIT SHALL be ignored.

Reset
REQ-034 RST=0 SHALL immediately force: state IDLE, PC=RESET_PC, Instr=0, squash=0, MisalignErr=0.
REQ-035 Resulting outputs: IReqValid=0, InstrValid=0, IReqAddr=RESET_PC, PCPlus4=RESET_PC+4.
REQ-036 Reset mid-fetch SHALL abandon the outstanding request; the next response is not squashed, memory must be reset together.

Configuration
REQ-037 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with PCTarget[1:0]!=0 SHALL be ignored (no PC/state change), and MisalignErr SHALL pulse 1 for one cycle.
REQ-038 Macro undefined: PCTarget[1:0] SHALL be treated as 2'b00, every redirect accepted, MisalignErr tied 0.

Verification
REQ-039 Reset release, IReqReady=1, IRespValid one cycle after accept with 32'h00500093 -> IReqAddr=0, then Instr=32'h00500093, InstrValid=1, PC=0.
REQ-040 Three back-to-back fetches with InstrReady=1 -> IReqAddr sequence 0, 4, 8.
REQ-041 InstrReady=0 for 5 cycles in HOLD -> InstrValid and Instr stable, IReqValid=0, PC unchanged.
REQ-042 PCSrc=1, PCTarget=32'h00000100 in WAIT -> stale response dropped, next IReqAddr=32'h00000100.
REQ-043 PC forced to 32'hFFFFFFFC via redirect, consumed -> next IReqAddr=32'h00000000.
REQ-044 With FETCH_MISALIGN_CHECK_EN, PCTarget=32'h00000102 -> MisalignErr=1 one cycle, PC unchanged; without macro -> next IReqAddr=32'h00000100.
